imem_feeder: RTL and testbench

Instruction-side responder for the five-stage MIPS `cpu`: it owns the program store that answers the core's `pc` with `inst` in the same cycle and gates the core's `pcEn`. A host loads the program through a valid/ready word stream, then starts execution. The block detects a halt sentinel, drains the pipeline with NOPs, and reports completion, fetch errors and run length for the emulation harness.

---
 rtl/imem_feeder.sv | 142 ++++++++++++++
 tb/tb_imem_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_feeder.sv
// imem_feeder: instruction-side responder for the five-stage MIPS core.
// Holds the program store, answers pc with inst in the same cycle and gates pcEn.
// A host streams the program in (valid/ready); start launches execution. The halt
// sentinel is never forwarded; it stalls the PC and drains the pipeline with NOPs.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ld_valid/ld_ready     program word handshake; ld_data word, ld_last final word
//   start                 level-sampled run request (honoured only when ARMED)
//   pc / inst             byte address from core / combinational instruction
//   pcEn                  core PC update enable
//   done                  halted and drained
//   err_fetch             sticky out-of-range or misaligned fetch flag
//   prog_len              words loaded
//   run_cycles            cycles spent in RUN, saturating
module imem_feeder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          start,
  input  logic [31:0]   pc,
  output logic [31:0]   inst,
  output logic          pcEn,
  output logic          done,
  output logic          err_fetch,
  output logic [AW:0]   prog_len,
  output logic [31:0]   run_cycles
);

  localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {StLoad, StArmed, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic [31:0]     run_cycles_q, run_cycles_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            err_fetch_q, err_fetch_d;
  logic            mem_we;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [31:0]     fetch_word;
  logic            fetch_ok;

  assign idx        = pc[AW+1:2];
  assign fetch_word = mem[idx];
  assign fetch_ok   = (pc[1:0] == 2'b00) && (pc[31:AW+2] == '0) && ({1'b0, idx} < prog_len_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    run_cycles_d = run_cycles_q;
    drain_cnt_d  = drain_cnt_q;
    err_fetch_d  = err_fetch_q;
    mem_we       = 1'b0;
    ld_ready     = 1'b0;
    pcEn         = 1'b0;
    inst         = 32'h0;
    done         = 1'b0;

    case (state_q)
      StLoad: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Terminate on ld_last or when the store fills.
          if (ld_last || (wr_ptr_q == (AW+1)'(DEPTH - 1))) begin
            state_d    = StArmed;
            prog_len_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StArmed: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
        if (!fetch_ok) begin
          // Bad fetch feeds a NOP but never stalls the core.
          err_fetch_d = 1'b1;
          pcEn        = 1'b1;
        end else if (fetch_word == HALT_WORD) begin
          // Hold PC on the halt address and hide the sentinel from the core.
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else begin
          inst = fetch_word;
          pcEn = 1'b1;
        end
      end
      StDrain: begin
        if (drain_cnt_q == DCW'(DRAIN_CYC - 1)) state_d = StDone;
        else drain_cnt_d = drain_cnt_q + 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      run_cycles_q <= '0;
      drain_cnt_q  <= '0;
      err_fetch_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      run_cycles_q <= run_cycles_d;
      drain_cnt_q  <= drain_cnt_d;
      err_fetch_q  <= err_fetch_d;
    end
  end

  // Program store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[wr_ptr_q[AW-1:0]] <= ld_data;
  end

  assign err_fetch  = err_fetch_q;
  assign prog_len   = prog_len_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_imem_feeder.sv
module tb_imem_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = 32'h0;
  logic        ld_last = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] inst;
  logic        pcEn;
  logic        done;
  logic        err_fetch;
  logic [8:0]  prog_len;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .start      (start),
    .pc         (pc),
    .inst       (inst),
    .pcEn       (pcEn),
    .done       (done),
    .err_fetch  (err_fetch),
    .prog_len   (prog_len),
    .run_cycles (run_cycles)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0; pc = 32'h0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 32'h0;
    step(); step();
    reset = 1'b0;
    settle();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    checks++; if (pcEn !== 1'b0) begin errors++; $display("FAIL reset_pcEn: got %b want 0", pcEn); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
    checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL reset_run_cycles: got %0d want 0", run_cycles); end
    checks++; if (err_fetch !== 1'b0) begin errors++; $display("FAIL reset_err_fetch: got %b want 0", err_fetch); end
  endtask

  task automatic test_basic_program();
    do_reset();
    load_word(32'h2001_0005, 1'b0);
    load_word(32'h2002_0007, 1'b0);
    load_word(32'hFFFF_FFFF, 1'b1);
    checks++; if (prog_len !== 9'd3) begin errors++; $display("FAIL basic_prog_len: got %0d want 3", prog_len); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ld_ready_armed: got %b want 0", ld_ready); end
    // ARMED: inst is NOP whatever pc says
    pc = 32'h0; settle();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL basic_inst_armed: got %h want 0", inst); end
    start = 1'b1;
    step();
    start = 1'b0;
    pc = 32'h0; settle();
    checks++; if (inst !== 32'h2001_0005) begin errors++; $display("FAIL basic_inst_pc0: got %h want 20010005", inst); end
    checks++; if (pcEn !== 1'b1) begin errors++; $display("FAIL basic_pcEn_pc0: got %b want 1", pcEn); end
    step();
    pc = 32'h4; settle();
    checks++; if (inst !== 32'h2002_0007) begin errors++; $display("FAIL basic_inst_pc4: got %h want 20020007", inst); end
    step();
    pc = 32'h8; settle();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL basic_halt_inst: got %h want 0", inst); end
    checks++; if (pcEn !== 1'b0) begin errors++; $display("FAIL basic_halt_pcEn: got %b want 0", pcEn); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (done !== 1'b0 || pcEn !== 1'b0 || inst !== 32'h0) begin
        errors++; $display("FAIL basic_drain%0d: got done=%b pcEn=%b inst=%h want 0 0 0", i, done, pcEn, inst);
      end
    end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    checks++; if (run_cycles !== 32'd3) begin errors++; $display("FAIL basic_run_cycles: got %0d want 3", run_cycles); end
    step(); step();
    checks++; if (done !== 1'b1 || pcEn !== 1'b0) begin errors++; $display("FAIL basic_done_hold: got done=%b pcEn=%b want 1 0", done, pcEn); end
  endtask

  task automatic test_full_load();
    do_reset();
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ld_data = 32'h1000_0000 | i;
      step();
    end
    checks++; if (prog_len !== 9'd256) begin errors++; $display("FAIL full_prog_len: got %0d want 256", prog_len); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %b want 0", ld_ready); end
    // Extra words while ARMED must be dropped.
    ld_data = 32'hDEAD_BEEF;
    step(); step();
    ld_valid = 1'b0;
    checks++; if (prog_len !== 9'd256) begin errors++; $display("FAIL full_prog_len_hold: got %0d want 256", prog_len); end
    start = 1'b1;
    step();
    start = 1'b0;
    pc = 32'h0; settle();
    checks++; if (inst !== 32'h1000_0000) begin errors++; $display("FAIL full_mem0: got %h want 10000000", inst); end
    pc = 32'd1020; settle();
    checks++; if (inst !== 32'h1000_00FF) begin errors++; $display("FAIL full_mem255: got %h want 100000ff", inst); end
    pc = 32'd1024; settle();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL full_oob_inst: got %h want 0", inst); end
    step();
    checks++; if (err_fetch !== 1'b1) begin errors++; $display("FAIL full_oob_err: got %b want 1", err_fetch); end
  endtask

  task automatic test_fetch_errors();
    do_reset();
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    pc = 32'h4; settle();
    step();
    checks++; if (err_fetch !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", err_fetch); end
    pc = 32'h8; settle();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL err_pc8_inst: got %h want 0", inst); end
    checks++; if (pcEn !== 1'b1) begin errors++; $display("FAIL err_pc8_pcEn: got %b want 1", pcEn); end
    step();
    checks++; if (err_fetch !== 1'b1) begin errors++; $display("FAIL err_pc8_flag: got %b want 1", err_fetch); end
    pc = 32'h2; settle();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL err_pc2_inst: got %h want 0", inst); end
    step();
    checks++; if (err_fetch !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_fetch); end
    pc = 32'h4; settle();
    checks++; if (inst !== 32'h2222_2222 || pcEn !== 1'b1) begin
      errors++; $display("FAIL err_continue: got inst=%h pcEn=%b want 22222222 1", inst, pcEn);
    end
  endtask

  task automatic test_start_in_load();
    do_reset();
    start = 1'b1;
    step(); step();
    checks++; if (ld_ready !== 1'b1 || pcEn !== 1'b0) begin
      errors++; $display("FAIL sil_stay_load: got ld_ready=%b pcEn=%b want 1 0", ld_ready, pcEn);
    end
    load_word(32'h3333_3333, 1'b0);
    load_word(32'h4444_4444, 1'b1);
    pc = 32'h0; settle();
    checks++; if (pcEn !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL sil_armed: got pcEn=%b ld_ready=%b want 0 0", pcEn, ld_ready);
    end
    step();
    checks++; if (pcEn !== 1'b1 || inst !== 32'h3333_3333) begin
      errors++; $display("FAIL sil_run: got pcEn=%b inst=%h want 1 33333333", pcEn, inst);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_word(32'h5555_5555, 1'b0);
    load_word(32'h6666_6666, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    pc = 32'h8; // provoke err_fetch so its reset is observable
    for (int i = 0; i < 9; i++) step();
    checks++; if (run_cycles !== 32'd9 || err_fetch !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got run_cycles=%0d err=%b want 9 1", run_cycles, err_fetch);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    checks++; if (pcEn !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ctrl: got pcEn=%b done=%b ld_ready=%b want 0 0 1", pcEn, done, ld_ready);
    end
    checks++; if (run_cycles !== 32'd0 || prog_len !== 9'd0 || err_fetch !== 1'b0) begin
      errors++; $display("FAIL mid_regs: got run=%0d len=%0d err=%b want 0 0 0", run_cycles, prog_len, err_fetch);
    end
  endtask

  task automatic test_gapped_load();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0; ld_data = 32'hBAD0_0000 | i; ld_last = (i == 3);
      step();
      load_word(32'hA000_0000 | i, (i == 3));
    end
    checks++; if (prog_len !== 9'd4) begin errors++; $display("FAIL gap_prog_len: got %0d want 4", prog_len); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(4 * i); settle();
      exp = 32'hA000_0000 | i;
      checks++; if (inst !== exp) begin errors++; $display("FAIL gap_mem%0d: got %h want %h", i, inst, exp); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_full_load();
    test_fetch_errors();
    test_start_in_load();
    test_reset_mid_run();
    test_gapped_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
